// File: rtl/i2c_pkg.sv
// Shared types and constants for the generic I2C master.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_STOP,
    ST_DONE
  } state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

endpackage

// File: rtl/i2c_phase_gen.sv
// Quarter-period tick generator; one bit period is four quarters of QTR_DIV clocks.
module i2c_phase_gen
  import i2c_pkg::*;
#(
  parameter int unsigned QTR_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [1:0] quarter,
  output logic       qtick,
  output logic       sample,
  output logic       bit_end
);

  localparam int unsigned QW = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;

  logic [QW-1:0] qcnt;

  // qtick marks the last clk cycle of the current quarter
  assign qtick   = en && (qcnt == QW'(QTR_DIV - 1));
  assign sample  = qtick && (quarter == Q2);
  assign bit_end = qtick && (quarter == Q3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qcnt    <= '0;
      quarter <= Q0;
    end else if (!en) begin
      qcnt    <= '0;
      quarter <= Q0;
    end else if (qtick) begin
      qcnt    <= '0;
      quarter <= quarter + 2'd1;
    end else begin
      qcnt <= qcnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_master_generic.sv
// I2C master: single write or read of NUM_BYTES bytes to a 7-bit address,
// ACK checked on every master-sent byte, NACK aborts to STOP with NACK_ERR.
module i2c_master_generic
  import i2c_pkg::*;
#(
  parameter int unsigned NUM_BYTES = 2,
  parameter int unsigned QTR_DIV   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   START_STB,
  input  logic                   RNW,
  input  logic [6:0]             I2C_ADDR,
  input  logic [8*NUM_BYTES-1:0] WR_DATA,
  input  logic                   SDA_IN,
  output logic                   SDA_OE,
  output logic                   SDA_OUT,
  output logic                   SCL,
  output logic [8*NUM_BYTES-1:0] RD_DATA,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   NACK_ERR
);

  localparam int unsigned DW = 8 * NUM_BYTES;
  localparam int unsigned BW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  state_t          state;
  logic            rnw_q;
  logic [DW-1:0]   wdata;
  logic [DW-1:0]   rshift;
  logic [7:0]      shreg;
  logic [2:0]      bit_idx;
  logic [BW-1:0]   byte_cnt;
  logic            ack_bit;
  logic            pg_en;
  logic [1:0]      quarter;
  logic            qtick;
  logic            sample;
  logic            bit_end;
  logic            last_byte;

  assign pg_en     = (state != ST_IDLE) && (state != ST_DONE);
  assign last_byte = (byte_cnt == BW'(NUM_BYTES - 1));

  i2c_phase_gen #(.QTR_DIV(QTR_DIV)) u_phase (
    .clk     (clk),
    .rst     (rst),
    .en      (pg_en),
    .quarter (quarter),
    .qtick   (qtick),
    .sample  (sample),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      SCL      <= 1'b1;
      SDA_OE   <= 1'b1;
      SDA_OUT  <= 1'b1;
      RD_DATA  <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      NACK_ERR <= 1'b0;
      rnw_q    <= 1'b0;
      wdata    <= '0;
      rshift   <= '0;
      shreg    <= '0;
      bit_idx  <= '0;
      byte_cnt <= '0;
      ack_bit  <= I2C_ACK;
    end else begin
      DONE <= 1'b0;

      // Outside START, SCL is low for q0/q1 and high for q2/q3; STOP leaves it high.
      if (qtick && (quarter == Q1) && (state != ST_START)) SCL <= 1'b1;
      if (bit_end && (state != ST_STOP)) SCL <= 1'b0;

      if (sample) begin
        ack_bit <= SDA_IN;
        if (state == ST_RD_BYTE) rshift <= {rshift[DW-2:0], SDA_IN};
      end

      case (state)
        ST_IDLE: begin
          if (START_STB) begin
            state    <= ST_START;
            BUSY     <= 1'b1;
            NACK_ERR <= 1'b0;
            rnw_q    <= RNW;
            wdata    <= WR_DATA;
            shreg    <= {I2C_ADDR, RNW};
            byte_cnt <= '0;
          end
        end

        ST_START: begin
          if (qtick && (quarter == Q0)) SDA_OUT <= 1'b0;
          if (qtick && (quarter == Q1)) SCL <= 1'b0;
          if (bit_end) begin
            state   <= ST_ADDR;
            SDA_OUT <= shreg[7];
            shreg   <= shreg << 1;
            bit_idx <= '0;
          end
        end

        ST_ADDR, ST_WR_BYTE: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              state   <= (state == ST_ADDR) ? ST_ADDR_ACK : ST_WR_ACK;
              SDA_OE  <= 1'b0;
              SDA_OUT <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              SDA_OUT <= shreg[7];
              shreg   <= shreg << 1;
            end
          end
        end

        ST_ADDR_ACK, ST_WR_ACK: begin
          if (bit_end) begin
            if (ack_bit == I2C_NACK || (state == ST_WR_ACK && last_byte)) begin
              if (ack_bit == I2C_NACK) NACK_ERR <= 1'b1;
              state   <= ST_STOP;
              SDA_OE  <= 1'b1;
              SDA_OUT <= 1'b0;
            end else if (state == ST_ADDR_ACK && rnw_q) begin
              state   <= ST_RD_BYTE;
              bit_idx <= '0;
            end else begin
              if (state == ST_WR_ACK) byte_cnt <= byte_cnt + 1'b1;
              state   <= ST_WR_BYTE;
              SDA_OE  <= 1'b1;
              SDA_OUT <= wdata[DW-1];
              shreg   <= wdata[DW-1 -: 8] << 1;
              wdata   <= wdata << 8;
              bit_idx <= '0;
            end
          end
        end

        ST_RD_BYTE: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              state   <= ST_RD_ACK;
              SDA_OE  <= 1'b1;
              SDA_OUT <= last_byte ? I2C_NACK : I2C_ACK;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end

        ST_RD_ACK: begin
          if (bit_end) begin
            if (last_byte) begin
              state   <= ST_STOP;
              SDA_OUT <= 1'b0;
            end else begin
              state    <= ST_RD_BYTE;
              byte_cnt <= byte_cnt + 1'b1;
              SDA_OE   <= 1'b0;
              SDA_OUT  <= 1'b1;
              bit_idx  <= '0;
            end
          end
        end

        ST_STOP: begin
          if (qtick && (quarter == Q2)) SDA_OUT <= 1'b1;
          if (bit_end) begin
            state <= ST_DONE;
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
            if (rnw_q && !NACK_ERR) RD_DATA <= rshift;
          end
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_generic.sv
// Bench for i2c_master_generic: two instances (2 bytes/div 4 and 3 bytes/div 1) share one slave model.
module tb_i2c_master_generic;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb0 = 1'b0;
  logic        stb1 = 1'b0;
  logic        rnw = 1'b0;
  logic [6:0]  addr = '0;
  logic [23:0] wdata = '0;
  logic        sda_in = 1'b1;
  logic        sel = 1'b0;

  logic        m0_oe, m0_out, m0_scl, m0_busy, m0_done, m0_nack;
  logic [15:0] m0_rd;
  logic        m1_oe, m1_out, m1_scl, m1_busy, m1_done, m1_nack;
  logic [23:0] m1_rd;

  logic scl_m, oe_m, out_m, done_m, busy_m, nack_m;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;

  logic [7:0] exp_bytes[$];
  logic       exp_macks[$];
  logic [7:0] slave_rd[0:2];
  logic       slave_addr_nack = 1'b0;

  always #5 clk = ~clk;

  i2c_master_generic #(.NUM_BYTES(2), .QTR_DIV(4)) dut0 (
    .clk(clk), .rst(rst), .START_STB(stb0), .RNW(rnw), .I2C_ADDR(addr),
    .WR_DATA(wdata[15:0]), .SDA_IN(sda_in), .SDA_OE(m0_oe), .SDA_OUT(m0_out),
    .SCL(m0_scl), .RD_DATA(m0_rd), .BUSY(m0_busy), .DONE(m0_done), .NACK_ERR(m0_nack)
  );

  i2c_master_generic #(.NUM_BYTES(3), .QTR_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .START_STB(stb1), .RNW(rnw), .I2C_ADDR(addr),
    .WR_DATA(wdata), .SDA_IN(sda_in), .SDA_OE(m1_oe), .SDA_OUT(m1_out),
    .SCL(m1_scl), .RD_DATA(m1_rd), .BUSY(m1_busy), .DONE(m1_done), .NACK_ERR(m1_nack)
  );

  assign scl_m  = sel ? m1_scl  : m0_scl;
  assign oe_m   = sel ? m1_oe   : m0_oe;
  assign out_m  = sel ? m1_out  : m0_out;
  assign done_m = sel ? m1_done : m0_done;
  assign busy_m = sel ? m1_busy : m0_busy;
  assign nack_m = sel ? m1_nack : m0_nack;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave model: decodes the selected master's bus, ACKs, returns read data
  // and pops the scoreboard for every byte / master ACK it observes.
  int         frame = 0;
  int         bitn = 0;
  logic [7:0] sh = '0;
  logic       is_read = 1'b0;
  logic       in_xfer = 1'b0;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic       bus;

  initial begin
    forever begin
      @(negedge clk);
      bus = oe_m ? out_m : sda_in;
      if (rst) begin
        in_xfer = 1'b0;
        sda_in  = 1'b1;
      end else if (prev_scl && scl_m && prev_sda && !bus) begin
        in_xfer = 1'b1;
        frame   = 0;
        bitn    = 0;
      end else if (prev_scl && scl_m && !prev_sda && bus) begin
        in_xfer = 1'b0;
        sda_in  = 1'b1;
      end else if (in_xfer && !prev_scl && scl_m) begin
        if (bitn < 8) begin
          sh = {sh[6:0], bus};
          bitn++;
          if (bitn == 8) begin
            if (frame == 0) is_read = sh[0];
            if (frame == 0 || !is_read) begin
              if (exp_bytes.size() == 0) check_eq("sb_unexpected_byte", {24'h0, sh}, 32'h100);
              else check_eq("slave_byte", {24'h0, sh}, {24'h0, exp_bytes.pop_front()});
            end
          end
        end else begin
          if (frame > 0 && is_read) begin
            check_eq("master_ack_oe", {31'h0, oe_m}, 32'h1);
            if (exp_macks.size() == 0) check_eq("sb_unexpected_ack", {31'h0, bus}, 32'h2);
            else check_eq("master_ack", {31'h0, bus}, {31'h0, exp_macks.pop_front()});
          end else begin
            check_eq("ack_slot_released", {31'h0, oe_m}, 32'h0);
          end
          frame++;
          bitn = 0;
        end
      end else if (in_xfer && prev_scl && !scl_m) begin
        if (bitn == 8 && (frame == 0 || !is_read)) sda_in = (frame == 0) ? slave_addr_nack : 1'b0;
        else if (bitn < 8 && frame > 0 && is_read && frame <= 3) sda_in = slave_rd[frame-1][7-bitn];
        else sda_in = 1'b1;
      end
      prev_scl = scl_m;
      prev_sda = oe_m ? out_m : sda_in;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done_m) n_done++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; drives START_STB for one cycle and waits for DONE.
  task automatic run_txn(input logic rw, input logic [6:0] a, input logic [23:0] wd,
                         input int exp_lat, input int stray_at, input string tag);
    int   cycles;
    logic got;
    rnw   = rw;
    addr  = a;
    wdata = wd;
    if (sel) stb1 = 1'b1; else stb0 = 1'b1;
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < 2000) begin
      @(negedge clk);
      cycles++;
      stb0 = 1'b0;
      stb1 = 1'b0;
      if (cycles == 1) begin
        check_eq({tag, "_busy_rise"}, {31'h0, busy_m}, 32'h1);
        check_eq({tag, "_nack_cleared"}, {31'h0, nack_m}, 32'h0);
      end
      if (cycles == stray_at) begin
        if (sel) stb1 = 1'b1; else stb0 = 1'b1;
        addr  = 7'h11;
        wdata = 24'hFFFFFF;
      end
      if (done_m) got = 1'b1;
    end
    check_eq({tag, "_done_seen"}, {31'h0, got}, 32'h1);
    check_eq({tag, "_latency"}, cycles, exp_lat);
    check_eq({tag, "_busy_low_at_done"}, {31'h0, busy_m}, 32'h0);
    @(negedge clk);
    check_eq({tag, "_done_one_cycle"}, {31'h0, done_m}, 32'h0);
    check_eq({tag, "_bytes_left"}, exp_bytes.size(), 0);
    check_eq({tag, "_acks_left"}, exp_macks.size(), 0);
  endtask

  int n_before;

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_scl", {31'h0, m0_scl}, 32'h1);
    check_eq("rst_sda_oe", {31'h0, m0_oe}, 32'h1);
    check_eq("rst_sda_out", {31'h0, m0_out}, 32'h1);
    check_eq("rst_rd_data", {16'h0, m0_rd}, 32'h0);
    check_eq("rst_busy", {31'h0, m0_busy}, 32'h0);
    check_eq("rst_done", {31'h0, m0_done}, 32'h0);
    check_eq("rst_nack", {31'h0, m0_nack}, 32'h0);
    check_eq("rst_rd_data_p3", {8'h0, m1_rd}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // write 0x1234 to 0x3D
    exp_bytes.push_back(8'h7A); exp_bytes.push_back(8'h12); exp_bytes.push_back(8'h34);
    run_txn(1'b0, 7'h3D, 24'h001234, 465, 0, "wr");
    check_eq("wr_nack", {31'h0, nack_m}, 32'h0);

    // read two bytes
    slave_rd[0] = 8'h56; slave_rd[1] = 8'h78; slave_rd[2] = 8'h00;
    exp_bytes.push_back(8'h7B);
    exp_macks.push_back(1'b0); exp_macks.push_back(1'b1);
    run_txn(1'b1, 7'h3D, 24'h0, 465, 0, "rd");
    check_eq("rd_data", {16'h0, m0_rd}, 32'h5678);
    check_eq("rd_nack", {31'h0, nack_m}, 32'h0);

    // address NACK on a read: START+ADDR+ACK+STOP = 11 bits
    slave_addr_nack = 1'b1;
    exp_bytes.push_back(8'h7B);
    run_txn(1'b1, 7'h3D, 24'h0, 177, 0, "anack");
    check_eq("anack_err", {31'h0, nack_m}, 32'h1);
    check_eq("anack_rd_hold", {16'h0, m0_rd}, 32'h5678);
    slave_addr_nack = 1'b0;

    // stray request 50 cycles in, then a request on the cycle after DONE
    n_before = n_done;
    exp_bytes.push_back(8'h7A); exp_bytes.push_back(8'hBE); exp_bytes.push_back(8'hEF);
    run_txn(1'b0, 7'h3D, 24'h00BEEF, 465, 50, "busy");
    check_eq("busy_single_done", n_done - n_before, 1);
    exp_bytes.push_back(8'h7A); exp_bytes.push_back(8'h0F); exp_bytes.push_back(8'h0F);
    run_txn(1'b0, 7'h3D, 24'h000F0F, 465, 0, "after_done");
    check_eq("after_done_count", n_done - n_before, 2);

    // reset during WR_BYTE
    exp_bytes.push_back(8'h7A);
    rnw = 1'b0; addr = 7'h3D; wdata = 24'h00CAFE; stb0 = 1'b1;
    @(negedge clk);
    stb0 = 1'b0;
    repeat (168) @(negedge clk);
    check_eq("rst_mid_pre_busy", {31'h0, m0_busy}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_mid_scl", {31'h0, m0_scl}, 32'h1);
    check_eq("rst_mid_sda_oe", {31'h0, m0_oe}, 32'h1);
    check_eq("rst_mid_sda_out", {31'h0, m0_out}, 32'h1);
    check_eq("rst_mid_busy", {31'h0, m0_busy}, 32'h0);
    @(negedge clk);
    #2 rst = 1'b0;
    check_eq("rst_mid_bytes_left", exp_bytes.size(), 0);
    exp_bytes.delete();
    @(negedge clk);
    exp_bytes.push_back(8'h7A); exp_bytes.push_back(8'hCA); exp_bytes.push_back(8'hFE);
    run_txn(1'b0, 7'h3D, 24'h00CAFE, 465, 0, "post_rst");

    // 3-byte / divide-by-1 instance
    sel = 1'b1;
    @(negedge clk);
    exp_bytes.push_back(8'h7A); exp_bytes.push_back(8'hA5);
    exp_bytes.push_back(8'hC3); exp_bytes.push_back(8'hF0);
    run_txn(1'b0, 7'h3D, 24'hA5C3F0, 153, 0, "p3_wr");
    slave_rd[0] = 8'h11; slave_rd[1] = 8'h22; slave_rd[2] = 8'h33;
    exp_bytes.push_back(8'h7B);
    exp_macks.push_back(1'b0); exp_macks.push_back(1'b0); exp_macks.push_back(1'b1);
    run_txn(1'b1, 7'h3D, 24'h0, 153, 0, "p3_rd");
    check_eq("p3_rd_data", {8'h0, m1_rd}, 32'h112233);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_master_generic.md
Name: i2c_master_generic

Overview:
Parametrised I2C master transaction generator, the successor to the fixed 16-bit generator. It performs single write or read transactions of NUM_BYTES data bytes to a 7-bit slave address. SCL rate is set by a divider. Slave ACK is checked on every byte the master sends, and a NACK aborts the transaction with an error flag. It sits between a register/CPU side (START_STB handshake) and the I2C pad logic (SDA_OE/SDA_OUT/SDA_IN, SCL), and pairs with the existing receptor.

Parameters:
- NUM_BYTES, 2, data bytes per transaction; must be >= 1.
- QTR_DIV, 4, clk cycles per SCL quarter-period; must be >= 1. One bit period is 4*QTR_DIV clk cycles.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- START_STB  in  1  single-cycle request; ignored while BUSY=1
- RNW  in  1  1 = read, 0 = write; sampled with START_STB
- I2C_ADDR  in  7  slave address; sampled with START_STB
- WR_DATA  in  8*NUM_BYTES  write payload; sampled with START_STB
- SDA_IN  in  1  bus SDA value from the slave/pad
- SDA_OE  out  1  1 = master drives SDA_OUT onto the bus
- SDA_OUT  out  1  master SDA value
- SCL  out  1  bus clock
- RD_DATA  out  8*NUM_BYTES  read payload
- BUSY  out  1  transaction in progress
- DONE  out  1  one-cycle pulse at transaction end
- NACK_ERR  out  1  last transaction aborted on slave NACK; sticky until the next START_STB

Behaviour:
- Reset values (asynchronous, immediate): SCL=1, SDA_OE=1, SDA_OUT=1, RD_DATA=0, BUSY=0, DONE=0, NACK_ERR=0, state=IDLE. A reset mid-transfer drives the bus to idle at once and takes no further action.
- Accepting a request: START_STB=1 in IDLE latches RNW, I2C_ADDR and WR_DATA, and clears NACK_ERR. BUSY rises on the next cycle.
- Bit timing: each bit period has quarters q0..q3.
  - q0 and q1: SCL=0.
  - q2 and q3: SCL=1.
  - Master SDA changes only at the start of q0.
  - SDA_IN is sampled on the last clk cycle of q2.
- States and sequence:
  - IDLE
  - START (1 bit period): SDA falls while SCL=1 in the first half, then SCL goes low.
  - ADDR: 8 bits, I2C_ADDR[6:0] followed by RNW, MSB first.
  - ADDR_ACK: SDA_OE=0; sample SDA_IN.
  - Write path: WR_BYTE (SDA_OE=1) followed by WR_ACK (SDA_OE=0, sample) for each byte.
  - Read path: RD_BYTE (SDA_OE=0, shift SDA_IN) followed by RD_ACK (SDA_OE=1) for each byte.
  - STOP (1 bit period): SDA=0 while SCL rises, then SDA rises while SCL=1.
  - DONE, then IDLE.
- Byte order: byte NUM_BYTES-1 (bits [8*NUM_BYTES-1 -: 8]) goes first and each byte is sent MSB first. WR_DATA 0x1234 therefore transmits 0x12 then 0x34. Read bytes fill RD_DATA in the same order.
- Master ACK on reads: SDA_OUT=0 (ACK) after every read byte except the last, and SDA_OUT=1 (NACK) after the last.
- SDA_IN=1 in ADDR_ACK or any WR_ACK: set NACK_ERR, skip the remaining bytes, go to STOP. DONE still pulses.
- RD_DATA updates only on successful read completion (same cycle as DONE); it holds its value otherwise.
- DONE is high for 1 cycle; BUSY falls in the same cycle. A new START_STB is accepted from the following cycle.
- Latency: START_STB to DONE = 1 + 4*QTR_DIV*(2 + 9*(1+NUM_BYTES)) cycles. Defaults give 1 + 16*29 = 465 cycles.
- START_STB during BUSY has no effect and is not queued. Changes to RNW, I2C_ADDR or WR_DATA during BUSY have no effect.
- Idle bus: SCL=1, SDA_OE=1, SDA_OUT=1.

Decomposition:
- Package i2c_pkg holds:
  - state enumeration (IDLE, START, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, STOP, DONE)
  - constants I2C_ACK=0, I2C_NACK=1
  - quarter index constants Q0..Q3
- Sub-module i2c_phase_gen generates the quarter ticks and the bit-period boundary strobe from QTR_DIV. It has an enable input, and its counter is cleared on disable.

Test Plan:
- Write: NUM_BYTES=2, QTR_DIV=4, ADDR=0x3D, RNW=0, WR_DATA=0x1234; slave model ACKs everything.
  - Slave captures address byte 0x7A, then 0x12 and 0x34.
  - DONE at cycle 465 after START_STB; NACK_ERR=0.
- Read: ADDR=0x3D, RNW=1; slave returns 0x56 then 0x78.
  - RD_DATA=0x5678 at DONE.
  - Master drives ACK after byte 1 and NACK after byte 2.
- Address NACK: slave leaves SDA_IN=1 during ADDR_ACK.
  - STOP follows immediately; NACK_ERR=1; DONE pulses; RD_DATA unchanged.
- Busy request: second START_STB issued 50 cycles into a transfer.
  - Ignored; exactly one DONE is produced.
  - A request issued 1 cycle after DONE is accepted.
- Reset mid-transfer: rst pulsed during WR_BYTE.
  - SCL=1, SDA_OE=1, SDA_OUT=1, BUSY=0 in the same cycle.
  - A new write afterwards completes correctly.
- Parametric: NUM_BYTES=3, QTR_DIV=1, write 0xA5C3F0.
  - Bytes A5, C3, F0 transmitted in that order.
  - Latency 1 + 4*38 = 153 cycles.
